// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// instruction-memory port and buffers fetched words in a 2-entry queue for ID.
module fetch_unit #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C0D,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [29:0] cur_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [29:0] if_pc,
    output logic [31:0] if_instr
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [1:0]  count, count_next;
    logic        wr_ptr, rd_ptr;
    logic [29:0] drop_addr, drop_addr_next;
    logic [29:0] cur_pc_next;
    logic        push, pop;

    logic [29:0] pc_q    [2];
    logic [31:0] instr_q [2];

    // Redirect dominates push and pop so a flush never leaves a stale entry.
    always_comb begin
        push           = (state == REQ) && imem_ack && !redirect;
        pop            = (count != 2'd0) && !stall && !redirect;
        count_next     = redirect ? 2'd0 : (count + 2'(push) - 2'(pop));
        state_next     = state;
        cur_pc_next    = cur_pc;
        drop_addr_next = drop_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    cur_pc_next = next_pc;
                    state_next  = REQ;
                end else if (count_next < FULL) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    cur_pc_next = next_pc;
                    if (!imem_ack) begin
                        drop_addr_next = cur_pc;
                        state_next     = DROP;
                    end
                end else if (imem_ack) begin
                    cur_pc_next = next_pc;
                    state_next  = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The killed request keeps its address on the bus until its ack.
                if (redirect) cur_pc_next = next_pc;
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            cur_pc    <= RESET_PC;
            drop_addr <= 30'd0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            cur_pc    <= cur_pc_next;
            drop_addr <= drop_addr_next;
            if (redirect) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr ^ push;
                rd_ptr <= rd_ptr ^ pop;
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= cur_pc;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DROP) ? drop_addr : cur_pc;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = if_valid ? pc_q[rd_ptr] : 30'd0;
    assign if_instr  = if_valid ? instr_q[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a configurable wait-state memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [29:0] cur_pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [29:0] if_pc;
    logic [31:0] if_instr;

    int checks   = 0;
    int failures = 0;
    int wait_states = 0;
    int wcnt = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .cur_pc     (cur_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hDEAD_BEEF;
    endfunction

    // Memory response and default sequential next_pc for the current cycle.
    task automatic drive_mem();
        next_pc = cur_pc + 30'd1;
        if (imem_req && wcnt >= wait_states) begin
            imem_ack   = 1'b1;
            imem_rdata = word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    task automatic step();
        bit acked;
        bit reqd;
        acked = imem_req && imem_ack;
        reqd  = imem_req;
        @(posedge clk);
        #1;
        if (acked || !imem_req) wcnt = 0;
        else if (reqd) wcnt++;
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wait_states = 0;
        do_reset();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
        checks++; if (imem_addr !== 30'hC0D) begin failures++; $display("FAIL reset_addr got=%0h exp=c0d", imem_addr); end
        checks++; if (cur_pc !== 30'hC0D) begin failures++; $display("FAIL reset_cur_pc got=%0h exp=c0d", cur_pc); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", if_valid); end
        checks++; if (if_pc !== 30'h0) begin failures++; $display("FAIL reset_if_pc got=%0h exp=0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%0h exp=0", if_instr); end
    endtask

    task automatic test_zero_wait();
        wait_states = 0;
        do_reset();
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'hC0D) begin failures++; $display("FAIL zw_first_req got=%0h/%0h exp=1/c0d", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL zw_first_valid got=%0h exp=0", if_valid); end
        step();
        for (int k = 0; k < 3; k++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 30'hC0D + 30'(k)) begin failures++; $display("FAIL zw_if_pc%0d got=%0h/%0h exp=1/%0h", k, if_valid, if_pc, 30'hC0D + 30'(k)); end
            checks++; if (if_instr !== word(30'hC0D + 30'(k))) begin failures++; $display("FAIL zw_if_instr%0d got=%0h exp=%0h", k, if_instr, word(30'hC0D + 30'(k))); end
            checks++; if (imem_addr !== 30'hC0E + 30'(k)) begin failures++; $display("FAIL zw_addr%0d got=%0h exp=%0h", k, imem_addr, 30'hC0E + 30'(k)); end
            step();
        end
    endtask

    task automatic test_stall();
        wait_states = 0;
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== 30'hC0D) begin failures++; $display("FAIL stall_hold%0d got=%0h/%0h exp=1/c0d", i, if_valid, if_pc); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req%0d got=%0h exp=0", i, imem_req); end
        end
        stall = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'hC0F) begin failures++; $display("FAIL stall_restart got=%0h/%0h exp=1/c0f", imem_req, imem_addr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 30'hC0E + 30'(k)) begin failures++; $display("FAIL stall_resume%0d got=%0h/%0h exp=1/%0h", k, if_valid, if_pc, 30'hC0E + 30'(k)); end
            step();
        end
    endtask

    task automatic test_redirect_wait();
        bit seen;
        wait_states = 3;
        do_reset();
        step();
        step();
        redirect = 1'b1; next_pc = 30'h100;
        step();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'hC0D) begin failures++; $display("FAIL drop_addr got=%0h/%0h exp=1/c0d", imem_req, imem_addr); end
        checks++; if (cur_pc !== 30'h100 || if_valid !== 1'b0) begin failures++; $display("FAIL drop_cur_pc got=%0h/%0h exp=100/0", cur_pc, if_valid); end
        step();
        checks++; if (imem_addr !== 30'hC0D || imem_ack !== 1'b1) begin failures++; $display("FAIL drop_ack_addr got=%0h/%0h exp=c0d/1", imem_addr, imem_ack); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h100 || if_valid !== 1'b0) begin failures++; $display("FAIL drop_newreq got=%0h/%0h/%0h exp=1/100/0", imem_req, imem_addr, if_valid); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = if_valid;
        end
        checks++; if (if_valid !== 1'b1 || if_pc !== 30'h100) begin failures++; $display("FAIL drop_first_pc got=%0h/%0h exp=1/100", if_valid, if_pc); end
        checks++; if (if_instr !== word(30'h100)) begin failures++; $display("FAIL drop_first_instr got=%0h exp=%0h", if_instr, word(30'h100)); end
    endtask

    task automatic test_redirect_ack();
        wait_states = 0;
        do_reset();
        step();
        step();
        redirect = 1'b1; next_pc = 30'h200;
        step();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rack_valid got=%0h exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h200 || cur_pc !== 30'h200) begin failures++; $display("FAIL rack_addr got=%0h/%0h/%0h exp=1/200/200", imem_req, imem_addr, cur_pc); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 30'h200 || if_instr !== word(30'h200)) begin failures++; $display("FAIL rack_head got=%0h/%0h/%0h exp=1/200/%0h", if_valid, if_pc, if_instr, word(30'h200)); end
    endtask

    task automatic test_redirect_pop();
        wait_states = 0;
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL rpop_full got=%0h/%0h exp=1/0", if_valid, imem_req); end
        stall = 1'b0; redirect = 1'b1; next_pc = 30'h300;
        step();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rpop_valid got=%0h exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h300) begin failures++; $display("FAIL rpop_addr got=%0h/%0h exp=1/300", imem_req, imem_addr); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 30'h300) begin failures++; $display("FAIL rpop_head got=%0h/%0h exp=1/300", if_valid, if_pc); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 30'h301) begin failures++; $display("FAIL rpop_next got=%0h/%0h exp=1/301", if_valid, if_pc); end
    endtask

    task automatic test_rst_mid();
        bit seen;
        wait_states = 3;
        do_reset();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (imem_req !== 1'b0 || cur_pc !== 30'hC0D || if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_state got=%0h/%0h/%0h exp=0/c0d/0", imem_req, cur_pc, if_valid); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 30'hC0D) begin failures++; $display("FAIL rstmid_restart got=%0h/%0h exp=1/c0d", imem_req, imem_addr); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = if_valid;
        end
        checks++; if (if_valid !== 1'b1 || if_pc !== 30'hC0D || if_instr !== word(30'hC0D)) begin failures++; $display("FAIL rstmid_head got=%0h/%0h/%0h exp=1/c0d/%0h", if_valid, if_pc, if_instr, word(30'hC0D)); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        next_pc = 30'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_pop();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
